apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares a single APB master port between NUM_REQ on-chip requesters.
- Each requester issues one read or write command through a valid/ready handshake. The block picks one requester round-robin and sequences the APB SETUP and ACCESS phases.
- It waits for pready, with a bounded timeout, then returns read data or an error to the requester that was granted.
- It sits between the system-side command sources and the APB slave memory, and is the only driver of psel, penable, pwrite, paddr and pwdata.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, paddr width.
- DATA_W, 32, pwdata/prdata width.
- TIMEOUT, 16, maximum ACCESS cycles with pready low before abort (>=1).

Ports:
- pclk  in  1  APB clock; one clock for the whole block.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accept (one-hot or zero).
- req_write  in  NUM_REQ  1=write, 0=read, per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_W  read data, shared, qualified by rsp_valid.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- psel, penable, pwrite  out  1  APB control.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  APB slave ready.
- prdata  in  DATA_W  APB read data.

Behaviour:
- Reset (async, rst=1): all of the following clear immediately.
  - psel, penable, pwrite = 0; paddr, pwdata = 0.
  - rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - Timeout counter = 0.
  - FSM = IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transfer drops the transfer: no rsp_valid is ever issued for it.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Grant index g is the first i with req_valid[i]=1, searching from (last_grant+1) mod NUM_REQ and wrapping.
  - req_ready[g] = 1 combinationally, only in IDLE. All other req_ready bits = 0.
  - On the handshake, latch req_write[g], req_addr[g] and req_wdata[g] into pwrite, paddr and pwdata, set last_grant = g, and go to SETUP.
  - With no valid request, stay in IDLE with psel=0.
- SETUP: psel=1, penable=0 for exactly one cycle; then go to ACCESS.
- ACCESS:
  - psel=1, penable=1. paddr, pwrite and pwdata are held stable for the whole transfer.
  - pready=1 sampled:
    - Read: capture prdata into rsp_rdata. Write: rsp_rdata=0.
    - rsp_err=0; rsp_valid[last_grant]=1 on the next cycle.
    - psel and penable drop to 0 on the next cycle; go to IDLE.
  - pready=0: increment the counter. When the counter reaches TIMEOUT-1 with pready still low:
    - Abort: psel and penable drop to 0.
    - rsp_valid[last_grant]=1, rsp_err=1, rsp_rdata=0.
    - Go to IDLE.
  - The counter clears on entry to SETUP.
- rsp_valid is a single-cycle pulse, registered, at most one bit set. rsp_rdata and rsp_err hold their value until the next response.
- A new grant may occur in the same IDLE cycle in which rsp_valid pulses.
- Throughput: minimum 3 cycles per transfer (IDLE accept, SETUP, ACCESS with pready=1).
- A requester must hold req_write, req_addr and req_wdata stable while req_valid=1 and req_ready=0. Dropping req_valid before acceptance is allowed.
- last_grant updates only on an accepted handshake; requests that are not accepted never move the pointer.
- A requester is not blocked from re-requesting while it awaits its own response; ordering is preserved by serialization.

Decomposition:
- Package apb_ctrl_pkg holds:
  - The FSM state enum (IDLE, SETUP, ACCESS), 2 bits.
  - Default ADDR_W/DATA_W constants.
  - A packed command struct {write, addr, wdata}.
- Sub-module rr_arbiter, parameterized by NUM_REQ:
  - Inputs: req vector, last_grant pointer, enable.
  - Outputs: one-hot grant and its index; purely combinational.
- Top level: FSM, timeout counter, APB output registers and response registers.

Test Plan:
- Single write: req 0 writes addr 0x10, data 0xDEADBEEF, slave pready=1 at first ACCESS.
  - Expect psel high 2 cycles, penable high only in the 2nd, paddr=0x10, pwdata=0xDEADBEEF.
  - Expect rsp_valid[0] pulse with rsp_err=0, and a following read of 0x10 returning 0xDEADBEEF.
- Read with wait states: req 2 reads 0x05 (slave returns mem init 0x00000005), pready low for 3 ACCESS cycles.
  - Expect penable held 4 cycles and paddr stable throughout.
  - Expect rsp_valid[2] with rsp_rdata=0x5, rsp_err=0.
- Contention: reqs 0, 1 and 3 assert valid together and hold it, after reset.
  - Expect grant order 0, 1, 3, 0, with exactly one req_ready high per IDLE accept.
  - Expect each rsp_valid to go to the matching requester.
- Timeout: TIMEOUT=16, slave holds pready=0.
  - Expect the abort after 16 ACCESS cycles, psel/penable=0.
  - Expect rsp_valid for that requester with rsp_err=1, rsp_rdata=0.
  - Expect the next request to be served normally.
- Reset mid-ACCESS: assert rst during the ACCESS of req 1's write.
  - Expect psel, penable, rsp_valid = 0 immediately, with no response for req 1.
  - After release, req 1 and req 0 pending: expect req 0 granted first.
- Back-to-back: req 0 holds valid for 4 writes with pready=1.
  - Expect one transfer every 3 cycles, and psel low for exactly one cycle between transfers.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared definitions for the APB master arbiter: FSM state encoding,
// default bus widths and the requester command record.
package apb_ctrl_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from the slot after
// last_grant, wrapping, and reports the first requesting slot.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    input  logic                       enable,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int               cand;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        idx       = '0;
        if (enable) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = int'(last_grant) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                idx = IDX_W'(cand);
                if (!grant_any && req[idx]) begin
                    grant_any  = 1'b1;
                    grant_idx  = idx;
                    grant[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among NUM_REQ requesters: round-robin grant,
// SETUP/ACCESS sequencing, bounded pready wait and per-requester responses.
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata
);

    localparam int              IDX_W    = $clog2(NUM_REQ);
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_t          state;
    apb_state_t          state_next;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0]  grant;
    logic                grant_any;
    logic                accept;
    logic                xfer_done;
    logic                xfer_abort;
    logic [CNT_W-1:0]    wait_cnt;
    logic [NUM_REQ-1:0]  owner_onehot;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     (state == ST_IDLE),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    assign req_ready    = grant;
    assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << last_grant;

    always_comb begin
        sel_write = req_write[grant_idx];
        sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        xfer_done  = 1'b0;
        xfer_abort = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    accept     = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    xfer_done  = 1'b1;
                    state_next = ST_IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    xfer_abort = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // APB outputs are registered copies of the next state so they never glitch.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            psel    <= (state_next != ST_IDLE);
            penable <= (state_next == ST_ACCESS);
            if (accept) begin
                pwrite     <= sel_write;
                paddr      <= sel_addr;
                pwdata     <= sel_wdata;
                last_grant <= grant_idx;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && !pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Data and error hold between completions; only the valid bit pulses.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (xfer_done) begin
                rsp_valid <= owner_onehot;
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= 1'b0;
            end else if (xfer_abort) begin
                rsp_valid <= owner_onehot;
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a simple APB slave memory and
// a response scoreboard.
module tb_apb_master_arbiter;
    import apb_ctrl_pkg::*;

    logic         pclk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   req_write;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         psel;
    logic         penable;
    logic         pwrite;
    logic [31:0]  paddr;
    logic [31:0]  pwdata;
    logic         pready;
    logic [31:0]  prdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [256];
    bit   [255:0] mem_wr;
    int          acc_cnt = 0;
    int          wait_n  = 0;

    apb_master_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Slave: unwritten words read back as their own address.
    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && pwrite) begin
            mem[paddr[7:0]]    <= pwdata;
            mem_wr[paddr[7:0]] <= 1'b1;
        end
    end
    assign pready = psel && penable && (acc_cnt >= wait_n);
    assign prdata = mem_wr[paddr[7:0]] ? mem[paddr[7:0]] : {24'd0, paddr[7:0]};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [31:0] rd, input logic err);
        exp_t e;
        e.idx   = idx;
        e.rdata = rd;
        e.err   = err;
        sb.push_back(e);
    endtask

    function automatic apb_cmd_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
        apb_cmd_t c;
        c.write = w;
        c.addr  = a;
        c.wdata = d;
        return c;
    endfunction

    always @(negedge pclk) begin
        exp_t e;
        if (rsp_valid !== 4'b0000) begin
            if (sb.size() == 0) begin
                check("rsp_spurious", {60'd0, rsp_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_owner", {60'd0, rsp_valid}, 64'd1 << e.idx);
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
            end
        end
    end

    // Present one command on requester i and return just after it is accepted.
    task automatic issue(input int i, input apb_cmd_t c);
        int n;
        @(posedge pclk); #1;
        req_write[i]            = c.write;
        req_addr[i*32 +: 32]    = c.addr;
        req_wdata[i*32 +: 32]   = c.wdata;
        req_valid[i]            = 1'b1;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (req_ready[i] !== 1'b1 && n < 100);
        check("issue_ready", {60'd0, req_ready}, 64'd1 << i);
        @(posedge pclk); #1;
        req_valid[i] = 1'b0;
    endtask

    // Hold requests for several grants; rem_in gives grants per requester.
    task automatic serve(input int n, input int ord[4], input int rem_in[4],
                         output int gcyc[4], output int lowcnt);
        int rem[4];
        int ng;
        int gi;
        rem    = rem_in;
        ng     = 0;
        lowcnt = 0;
        gcyc   = '{0, 0, 0, 0};
        @(posedge pclk); #1;
        for (int i = 0; i < 4; i++) req_valid[i] = (rem[i] > 0);
        for (int c = 0; c < 80 && ng < n; c++) begin
            @(negedge pclk);
            if (ng >= 1 && psel === 1'b0) lowcnt++;
            if (req_ready !== 4'b0000) begin
                check("grant_onehot", $countones(req_ready), 1);
                gi = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) gi = i;
                check("grant_order", gi, ord[ng]);
                gcyc[ng] = c;
                ng++;
                @(posedge pclk); #1;
                req_wdata[gi*32 +: 32] = req_wdata[gi*32 +: 32] + 32'd1;
                if (rem[gi] > 0) rem[gi]--;
                if (rem[gi] == 0) req_valid[gi] = 1'b0;
            end
        end
        check("grant_count", ng, n);
        req_valid = 4'b0000;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || psel !== 1'b0) && n < 200) begin
            @(negedge pclk);
            n++;
        end
        @(negedge pclk);
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gc[4];
        int lc;
        int n_en;

        rst       = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        @(negedge pclk);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_ready", req_ready, 0);
        rst = 1'b0;

        // Single write then read-back
        wait_n = 0;
        push_exp(0, 32'h0, 1'b0);
        issue(0, mk(1'b1, 32'h10, 32'hDEADBEEF));
        @(negedge pclk);
        check("wr_setup_psel", psel, 1);
        check("wr_setup_penable", penable, 0);
        check("wr_paddr", paddr, 32'h10);
        check("wr_pwdata", pwdata, 32'hDEADBEEF);
        check("wr_pwrite", pwrite, 1);
        @(negedge pclk);
        check("wr_access_psel", psel, 1);
        check("wr_access_penable", penable, 1);
        @(negedge pclk);
        check("wr_end_psel", psel, 0);
        check("wr_end_penable", penable, 0);
        drain();
        push_exp(0, 32'hDEADBEEF, 1'b0);
        issue(0, mk(1'b0, 32'h10, 32'h0));
        drain();

        // Read with three wait states
        wait_n = 3;
        push_exp(2, 32'h5, 1'b0);
        issue(2, mk(1'b0, 32'h05, 32'h0));
        n_en = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge pclk);
            if (psel) check("ws_paddr_stable", paddr, 32'h05);
            if (penable) n_en++;
        end
        check("ws_penable_cycles", n_en, 4);
        drain();
        wait_n = 0;

        // Contention after reset: 0, 1, 3 hold valid; 0 wants two transfers
        @(negedge pclk); rst = 1'b1;
        @(negedge pclk); rst = 1'b0;
        req_write = 4'b0000;
        req_addr[0*32 +: 32] = 32'h20;
        req_addr[1*32 +: 32] = 32'h21;
        req_addr[3*32 +: 32] = 32'h23;
        push_exp(0, 32'h20, 1'b0);
        push_exp(1, 32'h21, 1'b0);
        push_exp(3, 32'h23, 1'b0);
        push_exp(0, 32'h20, 1'b0);
        serve(4, '{0, 1, 3, 0}, '{2, 1, 0, 1}, gc, lc);
        drain();

        // Timeout on a stalled read, then a normal transfer
        wait_n = 1000;
        push_exp(1, 32'h0, 1'b1);
        issue(1, mk(1'b0, 32'h30, 32'h0));
        n_en = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge pclk);
            if (penable) n_en++;
            else if (n_en > 0) break;
        end
        check("to_access_cycles", n_en, 16);
        check("to_psel_drop", psel, 0);
        check("to_penable_drop", penable, 0);
        wait_n = 0;
        drain();
        push_exp(2, 32'h7, 1'b0);
        issue(2, mk(1'b0, 32'h07, 32'h0));
        drain();

        // Reset during ACCESS of requester 1's write
        wait_n = 1000;
        issue(1, mk(1'b1, 32'h40, 32'h1234));
        @(negedge pclk);
        @(negedge pclk);
        check("mid_in_access", penable, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_psel", psel, 0);
        check("mid_rst_penable", penable, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        wait_n = 0;
        req_write[0] = 1'b0;
        req_write[1] = 1'b0;
        req_addr[0*32 +: 32] = 32'h41;
        req_addr[1*32 +: 32] = 32'h42;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        push_exp(0, 32'h41, 1'b0);
        push_exp(1, 32'h42, 1'b0);
        serve(2, '{0, 1, 0, 0}, '{1, 1, 0, 0}, gc, lc);
        drain();
        check("mid_no_write", {63'd0, mem_wr[8'h40]}, 64'd0);

        // Back-to-back writes from requester 0
        req_write[0]          = 1'b1;
        req_addr[0*32 +: 32]  = 32'h50;
        req_wdata[0*32 +: 32] = 32'hA0;
        for (int i = 0; i < 4; i++) push_exp(0, 32'h0, 1'b0);
        serve(4, '{0, 0, 0, 0}, '{4, 0, 0, 0}, gc, lc);
        check("b2b_gap1", gc[1] - gc[0], 3);
        check("b2b_gap2", gc[2] - gc[1], 3);
        check("b2b_gap3", gc[3] - gc[2], 3);
        check("b2b_psel_low", lc, 3);
        drain();
        push_exp(0, 32'hA3, 1'b0);
        issue(0, mk(1'b0, 32'h50, 32'h0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
